// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: RV32I load/store funct3 widths, the data-memory
// responder state encoding, and small helpers for decoding access legality.
package rv32i_pkg;

    // Load widths
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // Store widths
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // Legal funct3 encodings: stores only B/H/W, loads also BU/HU.
    function automatic logic f3_ok(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) ||
               ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/rv32i_lsu_lane.sv
// RV32I byte-lane steering. Store side: funct3 + addr[1:0] + right-aligned
// store data -> byte enables and lane-replicated write data. Load side: full
// read word + funct3 + addr[1:0] -> sign/zero-extended load value.
// Purely combinational; shared with the core's MEM stage.
module rv32i_lsu_lane
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] rshift;

    // Store steering: replicate the datum across lanes, enable only the target ones
    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = 32'h0;
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'(4'b0001 << addr_lo);
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            2'b10: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
            end
            default: begin
                byte_en    = 4'b0000;
                wdata_lane = 32'h0;
            end
        endcase
    end

    // Load extraction: shift the addressed lane down, then extend
    always_comb begin
        rshift    = rword >> {addr_lo, 3'b000};
        rdata_ext = 32'h0;
        case (funct3)
            F3_LB:   rdata_ext = {{24{rshift[7]}}, rshift[7:0]};
            F3_LH:   rdata_ext = {{16{rshift[15]}}, rshift[15:0]};
            F3_LW:   rdata_ext = rword;
            F3_LBU:  rdata_ext = {24'h0, rshift[7:0]};
            F3_LHU:  rdata_ext = {16'h0, rshift[15:0]};
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder (target side of the rv32i MEM-stage load/store port).
// One request in flight; response after a fixed one-cycle array read slot plus
// LATENCY wait cycles, so rsp_valid_o rises LATENCY+2 cycles after the accept.
// Optional build macro: DMEM_MISALIGN_TRAP_EN (misaligned H/W accesses fault
// instead of being silently aligned down).
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high; the initiator holds req_* stable while req_valid_i is high and
// not yet accepted, and this block holds rsp_* stable while rsp_valid_o is high
// and rsp_ready_i is low.
module rv32i_dmem_responder
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [1:0]  dbg_state_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]  dmem_r [DEPTH_WORDS];

    dmem_state_e  state;
    logic         ready_r;
    logic [3:0]   wait_cnt;
    logic         rd_issued;
    logic         we_r;
    logic [31:0]  addr_r;
    logic [31:0]  wdata_r;
    logic [2:0]   f3_r;
    logic [31:0]  rd_word_r;

    logic [32:0]      offs;
    logic [29:0]      word_idx;
    logic             out_of_range;
    logic [IDX_W-1:0] idx_safe;
    logic [1:0]       lo_eff;
    logic             misal_err;
    logic             acc_err;
    logic             access_now;
    logic             commit;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_lane;
    logic [31:0]      load_data;

    assign req_ready_o = ready_r && !rst_i && (state == DMEM_IDLE);
    assign dbg_state_o = state;

    // Address decode of the latched request: bit 32 of the subtraction flags underflow
    always_comb begin
        offs         = {1'b0, addr_r} - {1'b0, BASE_ADDR};
        word_idx     = offs[31:2];
        out_of_range = offs[32] || ({2'b00, word_idx} >= 32'(DEPTH_WORDS));
        idx_safe     = out_of_range ? '0 : word_idx[IDX_W-1:0];
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Misaligned halfword/word accesses fault; lane bits used as-is
    always_comb begin
        lo_eff    = offs[1:0];
        misal_err = misaligned(f3_r, offs[1:0]);
    end
`else
    // Misaligned halfword/word accesses are forced down to natural alignment
    always_comb begin
        lo_eff    = offs[1:0];
        misal_err = 1'b0;
        if (f3_r[1:0] == 2'b01) begin
            lo_eff = {offs[1], 1'b0};
        end else if (f3_r[1:0] == 2'b10) begin
            lo_eff = 2'b00;
        end
    end
`endif

    assign acc_err    = out_of_range || !f3_ok(we_r, f3_r) || misal_err;
    assign access_now = (state == DMEM_WAIT) && rd_issued && (wait_cnt == 4'd0);
    assign commit     = access_now && we_r && !acc_err && !rst_i;

    rv32i_lsu_lane u_lane (
        .funct3     (f3_r),
        .addr_lo    (lo_eff),
        .wdata      (wdata_r),
        .rword      (rd_word_r),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (load_data)
    );

    // Storage: synchronous read every cycle, byte-lane write only on the commit edge
    always_ff @(posedge clk_i) begin
        rd_word_r <= dmem_r[idx_safe];
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    dmem_r[idx_safe][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    // Request/response FSM with registered handshake outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= DMEM_IDLE;
            ready_r     <= 1'b0;
            wait_cnt    <= 4'd0;
            rd_issued   <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                DMEM_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        we_r      <= req_we_i;
                        addr_r    <= req_addr_i;
                        wdata_r   <= req_wdata_i;
                        f3_r      <= req_funct3_i;
                        wait_cnt  <= 4'(LATENCY);
                        rd_issued <= 1'b0;
                        ready_r   <= 1'b0;
                        state     <= DMEM_WAIT;
                    end else begin
                        ready_r   <= 1'b1;
                    end
                end
                DMEM_WAIT: begin
                    if (!rd_issued) begin
                        rd_issued <= 1'b1;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt  <= wait_cnt - 4'd1;
                    end else begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= acc_err;
                        rsp_rdata_o <= (acc_err || we_r) ? 32'h0 : load_data;
                        state       <= DMEM_RESP;
                    end
                end
                DMEM_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_rdata_o <= 32'h0;
                        rsp_err_o   <= 1'b0;
                        ready_r     <= 1'b1;
                        state       <= DMEM_IDLE;
                    end
                end
                default: begin
                    state <= DMEM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed bench for rv32i_dmem_responder with an expected-response queue.
module tb_rv32i_dmem_responder;
    import rv32i_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 3;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic [2:0]  req_funct3_i = 3'b000;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [1:0]  dbg_state_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic [32:0] exp_q[$];

    rv32i_dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0000_0000),
        .LATENCY     (LAT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_funct3_i (req_funct3_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .dbg_state_o  (dbg_state_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    // Drive one request, wait for its response, optionally stall, then compare and retire it
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input logic exp_err, input logic [31:0] exp_data, input int hold);
        int n;
        int cyc;
        logic [31:0] first_d;
        logic        first_e;
        logic        stable;
        logic [32:0] exp;
        exp_q.push_back({exp_err, exp_data});
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        req_funct3_i = f3;
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(posedge clk_i); #1; n++;
        end
        if (!req_ready_o) begin
            check({tag, "_accept_timeout"}, 32'd0, 32'd1);
            req_valid_i = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        cyc = 0;
        while (!rsp_valid_o && cyc < 50) begin
            @(posedge clk_i); #1; cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(LAT + 2));
        if (!rsp_valid_o) begin
            void'(exp_q.pop_front());
            return;
        end
        first_d = rsp_rdata_o;
        first_e = rsp_err_o;
        stable  = !req_ready_o;
        repeat (hold) begin
            @(posedge clk_i); #1;
            if (rsp_rdata_o !== first_d || rsp_err_o !== first_e || !rsp_valid_o || req_ready_o)
                stable = 1'b0;
        end
        check({tag, "_stall_stable"}, {31'h0, stable}, 32'd1);
        exp = exp_q.pop_front();
        check({tag, "_rdata"}, rsp_rdata_o, exp[31:0]);
        check({tag, "_err"}, {31'h0, rsp_err_o}, {31'h0, exp[32]});
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        check({tag, "_post_hs"}, {29'h0, rsp_valid_o, req_ready_o, (dbg_state_o == DMEM_IDLE)},
              32'b011);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", {31'h0, rsp_valid_o}, 32'd0);
        check("rst_ready", {31'h0, req_ready_o}, 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'h0);
        check("rst_err", {31'h0, rsp_err_o}, 32'd0);
        check("rst_state", {30'h0, dbg_state_o}, {30'h0, DMEM_IDLE});
        rst_i = 1'b0;

        // Reset in the middle of a store must discard it
        do_req("sw_10", 1'b1, 32'h10, 32'h1111_1111, F3_SW, 1'b0, 32'h0, 0);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_addr_i   = 32'h10;
        req_wdata_i  = 32'hDEAD_BEEF;
        req_funct3_i = F3_SW;
        for (int i = 0; i < 50 && !req_ready_o; i++) begin
            @(posedge clk_i); #1;
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("midrst_in_wait", {30'h0, dbg_state_o}, {30'h0, DMEM_WAIT});
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("midrst_valid", {31'h0, rsp_valid_o}, 32'd0);
        check("midrst_ready", {31'h0, req_ready_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        do_req("lw_10_after_rst", 1'b0, 32'h10, 32'h0, F3_LW, 1'b0, 32'h1111_1111, 0);

        // Latency and backpressure
        do_req("sw_0", 1'b1, 32'h0, 32'h1234_5678, F3_SW, 1'b0, 32'h0, 0);
        do_req("lw_0_stall", 1'b0, 32'h0, 32'h0, F3_LW, 1'b0, 32'h1234_5678, 4);

        // Lane writes and reads
        do_req("sw_20_zero", 1'b1, 32'h20, 32'h0, F3_SW, 1'b0, 32'h0, 0);
        do_req("sb_21", 1'b1, 32'h21, 32'hFFFF_FFAB, F3_SB, 1'b0, 32'h0, 1);
        do_req("lw_20_a", 1'b0, 32'h20, 32'h0, F3_LW, 1'b0, 32'h0000_AB00, 0);
        do_req("lb_21", 1'b0, 32'h21, 32'h0, F3_LB, 1'b0, 32'hFFFF_FFAB, 0);
        do_req("lbu_21", 1'b0, 32'h21, 32'h0, F3_LBU, 1'b0, 32'h0000_00AB, 0);
        do_req("lb_20", 1'b0, 32'h20, 32'h0, F3_LB, 1'b0, 32'h0, 0);
        do_req("sh_22", 1'b1, 32'h22, 32'h5555_8001, F3_SH, 1'b0, 32'h0, 0);
        do_req("lw_20_b", 1'b0, 32'h20, 32'h0, F3_LW, 1'b0, 32'h8001_AB00, 0);
        do_req("lh_22", 1'b0, 32'h22, 32'h0, F3_LH, 1'b0, 32'hFFFF_8001, 0);
        do_req("lhu_22", 1'b0, 32'h22, 32'h0, F3_LHU, 1'b0, 32'h0000_8001, 0);
        do_req("lh_20", 1'b0, 32'h20, 32'h0, F3_LH, 1'b0, 32'hFFFF_AB00, 0);

        // Range boundary: last word is valid, the next one faults
        do_req("sw_last", 1'b1, 32'h4 * DEPTH - 32'h4, 32'hA5A5_5A5A, F3_SW, 1'b0, 32'h0, 0);
        do_req("lw_last", 1'b0, 32'h4 * DEPTH - 32'h4, 32'h0, F3_LW, 1'b0, 32'hA5A5_5A5A, 0);
        do_req("lw_oor", 1'b0, 32'h4 * DEPTH, 32'h0, F3_LW, 1'b1, 32'h0, 2);
        do_req("sw_oor", 1'b1, 32'h4 * DEPTH, 32'hFFFF_FFFF, F3_SW, 1'b1, 32'h0, 0);
        do_req("lw_0_post_oor", 1'b0, 32'h0, 32'h0, F3_LW, 1'b0, 32'h1234_5678, 0);
        do_req("lw_last_post_oor", 1'b0, 32'h4 * DEPTH - 32'h4, 32'h0, F3_LW, 1'b0, 32'hA5A5_5A5A, 0);
        do_req("lw_20_post_oor", 1'b0, 32'h20, 32'h0, F3_LW, 1'b0, 32'h8001_AB00, 0);

        // Misalignment
        do_req("sw_20_cafe", 1'b1, 32'h20, 32'hCAFE_F00D, F3_SW, 1'b0, 32'h0, 0);
        do_req("lw_22_mis", 1'b0, 32'h22, 32'h0, F3_LW, TRAP, TRAP ? 32'h0 : 32'hCAFE_F00D, 0);
        do_req("lh_21_mis", 1'b0, 32'h21, 32'h0, F3_LH, TRAP, TRAP ? 32'h0 : 32'hFFFF_F00D, 0);
        do_req("sw_21_mis", 1'b1, 32'h21, 32'h0000_0000, F3_SW, TRAP, 32'h0, 0);
        do_req("lw_20_after_mis", 1'b0, 32'h20, 32'h0, F3_LW, 1'b0,
               TRAP ? 32'hCAFE_F00D : 32'h0, 0);

        // Invalid funct3
        do_req("sw_20_restore", 1'b1, 32'h20, 32'hCAFE_F00D, F3_SW, 1'b0, 32'h0, 0);
        do_req("ld_f3_011", 1'b0, 32'h20, 32'h0, 3'b011, 1'b1, 32'h0, 1);
        do_req("st_f3_011", 1'b1, 32'h20, 32'h0, 3'b011, 1'b1, 32'h0, 0);
        do_req("st_f3_100", 1'b1, 32'h20, 32'h0, 3'b100, 1'b1, 32'h0, 0);
        do_req("ld_f3_111", 1'b0, 32'h20, 32'h0, 3'b111, 1'b1, 32'h0, 0);
        do_req("lw_20_after_bad", 1'b0, 32'h20, 32'h0, F3_LW, 1'b0, 32'hCAFE_F00D, 0);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
